// File: rtl/shot_clock_display_pkg.sv
// Shared constants for the shot-clock display stage: active-low segment codes,
// the largest legal shot value and the buzzer FSM state encoding.
package shot_clock_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [4:0] MAX_SHOT  = 5'd24;

   typedef enum logic [1:0] {IDLE, SOUND, WAIT_REL} buzz_state_t;

endpackage

// File: rtl/shot_clock_display_if.sv
// Signal bundle between the shot-clock counter side (master) and the display stage (slave).
interface shot_clock_display_if;

   logic [4:0] valor;
   logic       buzzer_in;
   logic [6:0] seg;
   logic [1:0] an;
   logic       buzzer_out;

   modport master (output valor, buzzer_in, input seg, an, buzzer_out);
   modport slave  (input valor, buzzer_in, output seg, an, buzzer_out);

endinterface

// File: rtl/shot_clock_display_bcd_to_7seg.sv
// Pure lookup from one decimal digit (or dash request) to an active-low gfedcba code.
module bcd_to_7seg
   import shot_clock_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       dash,
   output logic [6:0] code
);

   always_comb begin
      code = SEG_BLANK;
      if (dash) begin
         code = SEG_DASH;
      end else begin
         case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/shot_clock_display.sv
// Two-digit multiplexed 7-segment driver with frame-synchronous sampling and a one-shot buzzer burst.
// Build option: LEADING_ZERO_BLANK_EN blanks a zero tens digit for in-range values.
module shot_clock_display
   import shot_clock_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned SCAN_HZ      = 1000,
   parameter int unsigned BUZZ_MS      = 1000,
   parameter int unsigned BUZZ_TONE_HZ = 2000
) (
   input  logic                  clock_in,
   input  logic                  reset,
   shot_clock_display_if.slave   bus
);

   localparam int unsigned SCAN_DIV    = CLK_HZ / (2 * SCAN_HZ);
   localparam int unsigned BUZZ_CYCLES = (CLK_HZ / 1000) * BUZZ_MS;
   localparam int unsigned TONE_DIV    = CLK_HZ / (2 * BUZZ_TONE_HZ);
   localparam int unsigned SCAN_W  = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
   localparam int unsigned BURST_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
   localparam int unsigned TONE_W  = (TONE_DIV > 1)    ? $clog2(TONE_DIV)    : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BUZZ_CYCLES - 1);
   localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_DIV - 1);

   logic [SCAN_W-1:0] scan_cnt;
   logic              digit_sel;
   logic [4:0]        shadow;
   logic [3:0]        tens, units, digit;
   logic              dash;
   logic [6:0]        code, seg_next, seg_q;
   logic [1:0]        an_q;

   // Shadow only reloads on the tens->units wrap, so both digits of a frame share one value.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         scan_cnt  <= '0;
         digit_sel <= 1'b0;
         shadow    <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt  <= '0;
         digit_sel <= ~digit_sel;
         if (digit_sel) shadow <= bus.valor;
      end else begin
         scan_cnt  <= scan_cnt + SCAN_W'(1);
      end
   end

   always_comb begin
      dash  = (shadow > MAX_SHOT);
      tens  = 4'd0;
      units = shadow[3:0];
      if (shadow >= 5'd20) begin
         tens  = 4'd2;
         units = 4'(shadow - 5'd20);
      end else if (shadow >= 5'd10) begin
         tens  = 4'd1;
         units = 4'(shadow - 5'd10);
      end
      digit = digit_sel ? tens : units;
   end

   bcd_to_7seg u_lut (
      .digit (digit),
      .dash  (dash),
      .code  (code)
   );

   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      seg_next = (digit_sel && !dash && (tens == 4'd0)) ? SEG_BLANK : code;
`else
      seg_next = code;
`endif
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         seg_q <= SEG_BLANK;
         an_q  <= 2'b11;
      end else begin
         seg_q <= seg_next;
         an_q  <= digit_sel ? 2'b01 : 2'b10;
      end
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;

   buzz_state_t        state, state_n;
   logic [BURST_W-1:0] burst_cnt, burst_n;
   logic [TONE_W-1:0]  tone_cnt, tone_cnt_n;
   logic               tone, tone_n;
   logic               buzz_prev;
   logic               rise;

   assign rise = bus.buzzer_in & ~buzz_prev;

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state     <= IDLE;
         burst_cnt <= '0;
         tone_cnt  <= '0;
         tone      <= 1'b0;
         buzz_prev <= 1'b0;
      end else begin
         state     <= state_n;
         burst_cnt <= burst_n;
         tone_cnt  <= tone_cnt_n;
         tone      <= tone_n;
         buzz_prev <= bus.buzzer_in;
      end
   end

   // Edges are only honoured in IDLE, so a burst can be neither retriggered nor cut short.
   always_comb begin
      state_n    = state;
      burst_n    = burst_cnt;
      tone_cnt_n = tone_cnt;
      tone_n     = tone;
      case (state)
         IDLE: begin
            tone_n = 1'b0;
            if (rise) begin
               state_n    = SOUND;
               burst_n    = '0;
               tone_cnt_n = '0;
            end
         end
         SOUND: begin
            burst_n = burst_cnt + BURST_W'(1);
            if (tone_cnt == TONE_LAST) begin
               tone_cnt_n = '0;
               tone_n     = ~tone;
            end else begin
               tone_cnt_n = tone_cnt + TONE_W'(1);
            end
            if (burst_cnt == BURST_LAST) begin
               tone_n  = 1'b0;
               state_n = bus.buzzer_in ? WAIT_REL : IDLE;
            end
         end
         WAIT_REL: begin
            tone_n = 1'b0;
            if (!bus.buzzer_in) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            tone_n  = 1'b0;
         end
      endcase
   end

   assign bus.buzzer_out = tone;

endmodule
